// File: rtl/regfile_dump.sv
// Register-file dump sequencer: walks an inclusive, wrapping address range over
// a registered read port and streams {addr,data} through a 2-entry output FIFO.
`timescale 1ns/1ps
module regfile_dump #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                              r_state, w_next;
  logic [ADDR_W-1:0]                   r_rf_addr;
  logic [ADDR_W:0]                     r_remaining;
  logic                                r_inflight;
  logic [ADDR_W-1:0]                   r_if_addr;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]   r_fd;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   r_fa;
  logic                                r_wptr, r_rptr;
  logic [1:0]                          r_count;

  logic              w_pop, w_push, w_issue, w_start, w_last_pop;
  logic [2:0]        w_level;
  logic [ADDR_W-1:0] w_span;

  assign w_pop   = out_valid & out_ready;
  assign w_push  = r_inflight;
  // Slots committed after this edge: buffered + word arriving from the file - word leaving.
  assign w_level = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_remaining != '0) && (w_level < 3'd2);
  assign w_start = start && (r_state != S_RUN);
  assign w_span  = last_addr - first_addr;
  assign w_last_pop = (r_state == S_RUN) && (r_remaining == '0) && !r_inflight &&
                      (r_count == 2'd1) && w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (w_last_pop) w_next = S_FINISH;
      S_FINISH: w_next = start ? S_RUN : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_addr   <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_if_addr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_start) begin
        r_rf_addr   <= first_addr;
        r_remaining <= {1'b0, w_span} + (ADDR_W+1)'(1);
      end else if (w_issue) begin
        r_if_addr   <= r_rf_addr;
        r_rf_addr   <= r_rf_addr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fd    <= '0;
      r_fa    <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fd[r_wptr] <= rf_data;
        r_fa[r_wptr] <= r_if_addr;
        r_wptr       <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rf_addr   = r_rf_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fd[r_rptr];
  assign out_addr  = r_fa[r_rptr];

endmodule
